// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: LRU assignment of note events to envelope voices with a forced gate-low gap.
// Define VOICE_STEAL_EN to steal the oldest voice when all are busy; otherwise such note-ons are dropped.
module voice_allocator #(
    parameter int VOICES        = 4,
    parameter int NOTE_W        = 7,
    parameter int RETRIG_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ev_valid,
    output logic                     ev_ready,
    input  logic                     ev_on,
    input  logic [NOTE_W-1:0]        ev_note,
    output logic [VOICES-1:0]        voice_gate,
    output logic [VOICES*NOTE_W-1:0] voice_note,
    output logic                     dropped
);

    localparam int RW = $clog2(VOICES);
    localparam int CW = 8;

    typedef enum logic {IDLE, COMMIT} ctrl_t;
    typedef enum logic [1:0] {V_FREE, V_ACTIVE, V_RETRIG} vstate_t;

    ctrl_t             state, state_nxt;
    logic              lat_on;
    logic [NOTE_W-1:0] lat_note;

    vstate_t           vst   [VOICES];
    logic [CW-1:0]     vcnt  [VOICES];
    logic [RW-1:0]     vrank [VOICES];
    logic [NOTE_W-1:0] vnote [VOICES];

    logic              hit_any, free_any, take, load, drop;
    logic [RW-1:0]     hit_idx, free_idx, free_rank, sel;
`ifdef VOICE_STEAL_EN
    logic [RW-1:0]     old_idx;
`endif

    // Handshake: an event transfers on a rising edge where ev_valid && ev_ready; ev_ready is
    // high only in IDLE outside reset, so the source must hold the event until that edge.
    always_comb begin
        state_nxt = state;
        ev_ready  = (state == IDLE) && !rst;
        case (state)
            IDLE:    if (ev_valid && ev_ready) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        hit_any   = 1'b0;
        hit_idx   = '0;
        free_any  = 1'b0;
        free_idx  = '0;
        free_rank = '0;
`ifdef VOICE_STEAL_EN
        old_idx   = '0;
`endif
        for (int i = 0; i < VOICES; i++) begin
            if (vst[i] != V_FREE && vnote[i] == lat_note) begin
                hit_any = 1'b1;
                hit_idx = RW'(i);
            end
            // Highest-ranked free voice is the least recently allocated one.
            if (vst[i] == V_FREE && (!free_any || vrank[i] > free_rank)) begin
                free_any  = 1'b1;
                free_idx  = RW'(i);
                free_rank = vrank[i];
            end
`ifdef VOICE_STEAL_EN
            if (vrank[i] == RW'(VOICES - 1)) old_idx = RW'(i);
`endif
        end
    end

    always_comb begin
        take = 1'b0;
        load = 1'b0;
        drop = 1'b0;
        sel  = '0;
        if (lat_on) begin
            if (hit_any) begin
                take = 1'b1;
                sel  = hit_idx;
            end else if (free_any) begin
                take = 1'b1;
                load = 1'b1;
                sel  = free_idx;
            end else begin
`ifdef VOICE_STEAL_EN
                take = 1'b1;
                load = 1'b1;
                sel  = old_idx;
`else
                drop = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lat_on   <= 1'b0;
            lat_note <= '0;
            dropped  <= 1'b0;
            for (int i = 0; i < VOICES; i++) begin
                vst[i]   <= V_FREE;
                vcnt[i]  <= '0;
                vrank[i] <= RW'(VOICES - 1 - i);
                vnote[i] <= '0;
            end
        end else begin
            state   <= state_nxt;
            dropped <= (state == COMMIT) && drop;
            if (state == IDLE && ev_valid) begin
                lat_on   <= ev_on;
                lat_note <= ev_note;
            end
            for (int i = 0; i < VOICES; i++) begin
                if (vst[i] == V_RETRIG) begin
                    if (vcnt[i] <= CW'(1)) begin
                        vst[i]  <= V_ACTIVE;
                        vcnt[i] <= '0;
                    end else begin
                        vcnt[i] <= vcnt[i] - CW'(1);
                    end
                end
                // A commit to this voice overrides its own countdown in the same cycle.
                if (state == COMMIT && take) begin
                    if (sel == RW'(i)) begin
                        vst[i]   <= V_RETRIG;
                        vcnt[i]  <= CW'(RETRIG_CYCLES);
                        vrank[i] <= '0;
                        if (load) vnote[i] <= lat_note;
                    end else if (vrank[i] < vrank[sel]) begin
                        vrank[i] <= vrank[i] + RW'(1);
                    end
                end
                if (state == COMMIT && !lat_on && hit_any && hit_idx == RW'(i)) begin
                    vst[i]  <= V_FREE;
                    vcnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        voice_gate = '0;
        voice_note = '0;
        for (int i = 0; i < VOICES; i++) begin
            voice_gate[i]                  = (vst[i] == V_ACTIVE);
            voice_note[i*NOTE_W +: NOTE_W] = vnote[i];
        end
    end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic note scheduler that shares a fixed pool of `envelope_generator` voices between incoming note events. It accepts note-on/note-off events over a valid/ready handshake and assigns each note to a voice, least-recently-allocated first. It drives each voice's `gate` and note number, and inserts a forced gate-low gap whenever a voice is retriggered or stolen so the downstream envelope restarts from its attack phase. It sits between the note source (MIDI/sequencer front end) and the per-voice oscillator plus envelope generator instances.

## Interface
- `VOICES`, 4: number of voices (2..8).
- `NOTE_W`, 7: note number width.
- `RETRIG_CYCLES`, 16: gate-low gap length in clocks on retrigger or steal (1..255).

- `clk` input 1: system clock; everything in this block is clocked by it.
- `rst` input 1: reset, synchronous, active-high.
- `ev_valid` input 1: event present.
- `ev_ready` output 1: block can accept an event.
- `ev_on` input 1: 1 = note-on, 0 = note-off.
- `ev_note` input NOTE_W: note number of the event.
- `voice_gate` output VOICES: per-voice gate to `envelope_generator.gate`.
- `voice_note` output VOICES*NOTE_W: per-voice note; voice i occupies bits [i*NOTE_W +: NOTE_W].
- `dropped` output 1: one-cycle pulse when a note-on is discarded.

## Operation
- **Controller FSM:** two states, IDLE and COMMIT.
  - IDLE: `ev_ready`=1. When `ev_valid`&&`ev_ready` is sampled, latch `ev_on` and `ev_note`, then go to COMMIT.
  - COMMIT: `ev_ready`=0. Apply the decision, then return to IDLE.
- **Per-voice state:** FREE (gate 0), ACTIVE (gate 1), or RETRIG (gate 0, gap counter running). Each voice also has an LRU rank from 0 (newest) to VOICES-1 (oldest). Ranks are always a permutation of 0..VOICES-1.
- **Note-on decision**, evaluated in priority order:
  1. Match: a voice in ACTIVE or RETRIG holds the same note. That voice enters RETRIG and its counter reloads to RETRIG_CYCLES. The note is unchanged.
  2. Free: among FREE voices, pick the one with the highest rank. It receives the new note and enters RETRIG.
  3. All busy: see Configuration.
- **Rank update:** applies to any voice that receives a note-on (cases 1–3). That voice's rank becomes 0. Every voice whose rank was below the chosen voice's old rank increments by 1. Ranks change on note-on only.
- **Note-off:**
  - The voice in ACTIVE or RETRIG holding `ev_note` goes to FREE and its gate goes to 0.
  - If no voice holds the note, the event is ignored and does not pulse `dropped`.
  - Duplicate notes cannot exist, because of the match rule.
- **RETRIG countdown:** the counter decrements once per cycle. When it reaches 0 the voice becomes ACTIVE and its gate goes to 1.
- **`voice_note`:** holds the last assigned note. FREE does not clear it.

## Timing
- **Reset values:**
  - `ev_ready`=0 while `rst`=1; it is 1 in the first cycle after `rst` deasserts.
  - All voices FREE, `voice_gate`=0, `voice_note`=0, `dropped`=0, all gap counters 0.
  - Rank of voice i = VOICES-1-i, so voice 0 is the oldest.
- **Reset behaviour:**
  - Events presented during reset are not accepted.
  - Reset in any state (including COMMIT or mid-gap) returns every voice to FREE on the next edge.
- **Event latency:**
  - Accept edge E0: event latched.
  - Edge E1 = E0+1: voice state, `voice_note`, and `dropped` update. `ev_ready` is high again after E1.
  - Throughput: one event per 2 clocks.
- **Gap timing:** a voice entering RETRIG at E1 shows gate 0 for exactly RETRIG_CYCLES cycles. Its gate rises at edge E1+RETRIG_CYCLES. This holds even if the voice was already gate-low.
- **`dropped`:** high only during the cycle after E1.
- **Source hold rule:** `ev_valid`, `ev_on`, and `ev_note` must hold until accepted. While `ev_ready`=0 they are don't-care.

## Configuration
- **`VOICE_STEAL_EN` defined:** when all voices are busy, a note-on steals the voice with rank VOICES-1 (the oldest). That voice takes the new note, enters RETRIG, and gets rank 0. `dropped` never asserts.
- **`VOICE_STEAL_EN` undefined:** when all voices are busy, the note-on is discarded. `dropped` pulses one cycle and no voice state or rank changes. The steal logic is absent.

## Test plan
All scenarios use VOICES=4 and RETRIG_CYCLES=16.
- **Reset then single note:** reset, then on 60 → `ev_ready` low 1 cycle; voice0 note=60 at E1; gate low 16 cycles, then high at E1+16; other gates stay 0.
- **Fill and steal (macro defined):** on 60, 62, 64, 65 → voices 0–3. Then on 67 → voice0 note=67, gate low 16 cycles then high; `dropped`=0.
- **Fill and drop (macro undefined):** same stimulus → on 67 gives a one-cycle `dropped` pulse; voices 0–3 keep 60/62/64/65 with gates 1.
- **Note-off and LRU reuse:** after the four voices are allocated, off 62 then off 60 → gates 1 and 0 go low at each E1. Then on 70 → voice0 (rank 3) gets 70; voice1 stays FREE.
- **Held-note retrigger:** voice0 ACTIVE on 60, then on 60 → voice0 gate low 16 cycles, note stays 60; no other voice changes; voice0 rank becomes 0.
- **Cancel and reset mid-gap:**
  - off 60 at gap cycle 5 → voice0 FREE, gate never rises.
  - Separately, `rst` asserted mid-gap → all gates 0 and `ev_ready` 0 on the next edge.
